reg_40xx_wr_arbiter: RTL and testbench

//  Round-robin arbiter that shares the two write ports of the 40-entry, 1-read/2-write register

---
 rtl/reg_40xx_wr_arbiter.sv | 118 +++++++++++
 tb/tb_reg_40xx_wr_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/reg_40xx_wr_arbiter.sv
// reg_40xx_wr_arbiter: round-robin sharing of the two register-file write ports among NUM_REQ requesters.
// Define WRARB_OUT_REG_EN to register the wr0/wr1 port outputs (+1 cycle latency).
module reg_40xx_wr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*6-1:0]     req_addr,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     wr0_en,
   output logic [5:0]               wr0_addr,
   output logic [WIDTH-1:0]         wr0_data,
   output logic                     wr1_en,
   output logic [5:0]               wr1_addr,
   output logic [WIDTH-1:0]         wr1_data,
   output logic                     err_oor,
   output logic [7:0]               defer_cnt
);
   localparam int PW = $clog2(NUM_REQ);
   logic [PW-1:0]      ptr, ptr_nxt, i0, i1, last;
   logic               g0, g1, conflict;
   logic [5:0]         a0, a1, cur;
   logic [NUM_REQ-1:0] rdy, oor;
   logic [WIDTH-1:0]   d0, d1;
   logic               c_en0, c_en1;
   logic [5:0]         c_a0, c_a1;
   logic [WIDTH-1:0]   c_d0, c_d1;
   int                 j;
   // a conflict is a same-address request met while port 1 is still free
   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      conflict = 1'b0;
      i0 = '0;
      i1 = '0;
      a0 = '0;
      a1 = '0;
      rdy = '0;
      oor = '0;
      cur = '0;
      j = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         cur = req_addr[6*j +: 6];
         if (req_valid[j]) begin
            if (cur >= 6'd40) begin
               oor[j] = 1'b1;
               rdy[j] = 1'b1;
            end else if (!g0) begin
               g0 = 1'b1;
               i0 = PW'(j);
               a0 = cur;
               rdy[j] = 1'b1;
            end else if (!g1) begin
               if (cur == a0) conflict = 1'b1;
               else begin
                  g1 = 1'b1;
                  i1 = PW'(j);
                  a1 = cur;
                  rdy[j] = 1'b1;
               end
            end
         end
      end
   end
   assign last    = g1 ? i1 : i0;
   assign ptr_nxt = !g0 ? ptr : (int'(last) == NUM_REQ-1 ? '0 : last + 1'b1);
   assign d0      = req_data[WIDTH*i0 +: WIDTH];
   assign d1      = req_data[WIDTH*i1 +: WIDTH];
   assign c_en0   = rst_n & g0;
   assign c_en1   = rst_n & g1;
   assign c_a0    = c_en0 ? a0 : '0;
   assign c_a1    = c_en1 ? a1 : '0;
   assign c_d0    = c_en0 ? d0 : '0;
   assign c_d1    = c_en1 ? d1 : '0;
   assign req_ready = rst_n ? rdy : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         err_oor   <= 1'b0;
         defer_cnt <= '0;
      end else begin
         ptr <= ptr_nxt;
         if (|oor) err_oor <= 1'b1;
         if (conflict && defer_cnt != 8'hff) defer_cnt <= defer_cnt + 8'd1;
      end
   end
`ifdef WRARB_OUT_REG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr0_en   <= 1'b0;
         wr0_addr <= '0;
         wr0_data <= '0;
         wr1_en   <= 1'b0;
         wr1_addr <= '0;
         wr1_data <= '0;
      end else begin
         wr0_en   <= c_en0;
         wr0_addr <= c_a0;
         wr0_data <= c_d0;
         wr1_en   <= c_en1;
         wr1_addr <= c_a1;
         wr1_data <= c_d1;
      end
   end
`else
   assign wr0_en   = c_en0;
   assign wr0_addr = c_a0;
   assign wr0_data = c_d0;
   assign wr1_en   = c_en1;
   assign wr1_addr = c_a1;
   assign wr1_data = c_d1;
`endif
endmodule

// File: tb/tb_reg_40xx_wr_arbiter.sv
// tb_reg_40xx_wr_arbiter: random and directed stimulus against a queue-based reference model.
module tb_reg_40xx_wr_arbiter;
   localparam int N = 4, W = 64;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [N-1:0] req_valid, req_ready;
   logic [N*6-1:0] req_addr;
   logic [N*W-1:0] req_data;
   logic wr0_en, wr1_en, err_oor;
   logic [5:0] wr0_addr, wr1_addr;
   logic [W-1:0] wr0_data, wr1_data;
   logic [7:0] defer_cnt;
   logic v [N];
   logic [5:0] a [N];
   logic [W-1:0] d [N];
   int m_ptr = 0, m_def = 0, e_nptr, nerr = 0, nchk = 0, wcount = 0;
   logic m_err = 1'b0;
   int gcnt [N];
   logic [N-1:0] e_rdy, last_rdy;
   logic e_en0, e_en1, e_conf, e_oor;
   logic [5:0] e_a0, e_a1;
   logic [W-1:0] e_d0, e_d1;
   logic r_en0 = 0, r_en1 = 0;
   logic [5:0] r_a0 = 0, r_a1 = 0;
   logic [W-1:0] r_d0 = 0, r_d1 = 0;

   reg_40xx_wr_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .err_oor(err_oor), .defer_cnt(defer_cnt)
   );

   always #5 clk = ~clk;

   always_comb
      for (int i = 0; i < N; i++) begin
         req_valid[i] = v[i];
         req_addr[6*i +: 6] = a[i];
         req_data[W*i +: W] = d[i];
      end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // reference: in-range valid requests listed in rotated order; first takes port 0,
   // first later one with a different address takes port 1
   task automatic model();
      int q[$];
      e_rdy = '0; e_en0 = 0; e_en1 = 0; e_a0 = 0; e_a1 = 0; e_d0 = 0; e_d1 = 0;
      e_conf = 0; e_oor = 0; e_nptr = m_ptr;
      for (int k = 0; k < N; k++) begin
         int jj = (m_ptr + k) % N;
         if (v[jj]) begin
            if (a[jj] >= 40) begin e_rdy[jj] = 1; e_oor = 1; end
            else q.push_back(jj);
         end
      end
      if (q.size() > 0) begin
         e_en0 = 1; e_a0 = a[q[0]]; e_d0 = d[q[0]]; e_rdy[q[0]] = 1;
         e_nptr = (q[0] + 1) % N;
         e_conf = q.size() > 1 && a[q[1]] == e_a0;
         for (int k = 1; k < q.size(); k++)
            if (!e_en1 && a[q[k]] != e_a0) begin
               e_en1 = 1; e_a1 = a[q[k]]; e_d1 = d[q[k]]; e_rdy[q[k]] = 1;
               e_nptr = (q[k] + 1) % N;
            end
      end
   endtask

   task automatic step();
      logic x_en0, x_en1;
      logic [5:0] x_a0, x_a1;
      logic [W-1:0] x_d0, x_d1;
      model();
      @(negedge clk);
`ifdef WRARB_OUT_REG_EN
      x_en0 = r_en0; x_a0 = r_a0; x_d0 = r_d0; x_en1 = r_en1; x_a1 = r_a1; x_d1 = r_d1;
`else
      x_en0 = e_en0; x_a0 = e_a0; x_d0 = e_d0; x_en1 = e_en1; x_a1 = e_a1; x_d1 = e_d1;
`endif
      chk("ready", req_ready, e_rdy);
      chk("wr0_en", wr0_en, x_en0);
      chk("wr0_addr", wr0_addr, x_a0);
      chk("wr0_data", wr0_data, x_d0);
      chk("wr1_en", wr1_en, x_en1);
      chk("wr1_addr", wr1_addr, x_a1);
      chk("wr1_data", wr1_data, x_d1);
      chk("err_oor", err_oor, m_err);
      chk("defer_cnt", defer_cnt, m_def);
      chk("invariant", wr0_en && wr1_en && wr0_addr == wr1_addr, 0);
      last_rdy = req_ready;
      wcount += int'(wr0_en) + int'(wr1_en);
      for (int i = 0; i < N; i++) if (v[i] && req_ready[i]) gcnt[i]++;
      @(posedge clk);
      m_ptr = e_nptr;
      m_err = m_err | e_oor;
      if (e_conf && m_def < 255) m_def++;
      r_en0 = e_en0; r_a0 = e_a0; r_d0 = e_d0; r_en1 = e_en1; r_a1 = e_a1; r_d1 = e_d1;
      #1;
      for (int i = 0; i < N; i++) if (e_rdy[i]) v[i] = 0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         v[i] = 1; a[i] = 6'(i + 1); d[i] = {$urandom, $urandom}; gcnt[i] = 0;
      end
      #3;
      chk("rst_ready", req_ready, 0);
      chk("rst_wr0_en", wr0_en, 0);
      chk("rst_wr1_en", wr1_en, 0);
      chk("rst_err", err_oor, 0);
      chk("rst_defer", defer_cnt, 0);
      @(posedge clk); #1;
      rst_n = 1;
      // all four valid, addresses 1..4
      step();
      chk("s2_first_rdy", last_rdy, 4'b0011);
      step();
      chk("s2_second_rdy", last_rdy, 4'b1100);
      step();
      chk("s2_writes", wcount, 4);
      // same-address pair
      v[0] = 1; a[0] = 7; d[0] = {$urandom, $urandom};
      v[1] = 1; a[1] = 7; d[1] = {$urandom, $urandom};
      step();
      chk("s3_first_rdy", last_rdy, 4'b0001);
      chk("s3_defer", defer_cnt, 1);
      step();
      chk("s3_second_rdy", last_rdy, 4'b0010);
      step();
      // out-of-range
      v[2] = 1; a[2] = 45; d[2] = {$urandom, $urandom};
      step();
      chk("s4_rdy", last_rdy, 4'b0100);
      chk("s4_err", err_oor, 1);
      // fairness with distinct addresses
      for (int i = 0; i < N; i++) gcnt[i] = 0;
      for (int c = 0; c < 100; c++) begin
         for (int i = 0; i < N; i++)
            if (!v[i]) begin v[i] = 1; a[i] = 6'(10 + i); d[i] = {$urandom, $urandom}; end
         step();
      end
      for (int i = 0; i < N; i++) chk("fair", gcnt[i] >= 49 && gcnt[i] <= 51, 1);
      // random traffic
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            if (!v[i] && $urandom_range(0, 3) != 0) begin
               v[i] = 1;
               a[i] = ($urandom_range(0, 9) == 0) ? 6'(40 + $urandom_range(0, 23)) : 6'($urandom_range(0, 5));
               d[i] = {$urandom, $urandom};
            end
         step();
      end
      for (int c = 0; c < 8; c++) step();
      // saturation: two requesters hammering one address
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < 2; i++)
            if (!v[i]) begin v[i] = 1; a[i] = 7; d[i] = {$urandom, $urandom}; end
         step();
      end
      chk("s6_defer_sat", defer_cnt, 255);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
